// File: rtl/rgb_seq_pkg.sv
// ---------------------------------------------------------------------------
// rgb_seq_pkg
// Shared definitions for the RGB fade sequencer: sequencer state encoding,
// colour word layout and channel/palette widths.
// No ports (package).
// ---------------------------------------------------------------------------
package rgb_seq_pkg;

  localparam int COLOR_W = 8;
  localparam int PAL_W   = 24;

  // Channel MSB positions inside a palette word {R, G, B}.
  localparam int R_MSB = 23;
  localparam int G_MSB = 15;
  localparam int B_MSB = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FADE = 2'd1,
    HOLD = 2'd2
  } seq_state_t;

endpackage

// File: rtl/rgb_channel_stepper.sv
// ---------------------------------------------------------------------------
// rgb_channel_stepper
// One colour channel of the fade engine. On each enabled step the value moves
// by one toward the target and never passes it.
// Ports:
//   clk, rst   clock, synchronous active-high reset (value -> 0)
//   step_en    move one LSB toward target this clk
//   target     channel value being faded to
//   value      current channel drive value
//   at_target  value equals target (combinational)
// ---------------------------------------------------------------------------
module rgb_channel_stepper
  import rgb_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               step_en,
  input  logic [COLOR_W-1:0] target,
  output logic [COLOR_W-1:0] value,
  output logic               at_target
);

  assign at_target = (value == target);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order between blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (step_en && !at_target) begin
      // Moving strictly toward target means no wrap is ever possible.
      value <= (value < target) ? value + 1'b1 : value - 1'b1;
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// ---------------------------------------------------------------------------
// rgb_fade_sequencer
// Palette-driven colour scheduler for an 8-bit RGB PWM LED controller.
// Walks palette entries 0..last_idx, fading linearly to each one and then
// dwelling on it; all pacing counts rising edges of the PWM sync flag.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   sync_i                PWM cycle-start flag (level, may last several clks)
//   wr_en/wr_addr/wr_data palette write port, {R,G,B} colour words
//   last_idx              highest palette index visited before wrapping
//   step_div              one fade step per (step_div+1) sync events
//   hold_len              sync events to dwell on each reached colour
//   start, stop           sequencing control pulses (stop has priority)
//   rcolor_o/gcolor_o/bcolor_o  channel drive values
//   busy                  sequencer in FADE or HOLD
//   cur_idx               palette index currently targeted
//   arrived               one-clk pulse when the target colour is reached
// ---------------------------------------------------------------------------
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sync_i,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [PAL_W-1:0]   wr_data,
  input  logic [AW-1:0]      last_idx,
  input  logic [7:0]         step_div,
  input  logic [15:0]        hold_len,
  input  logic               start,
  input  logic               stop,
  output logic [COLOR_W-1:0] rcolor_o,
  output logic [COLOR_W-1:0] gcolor_o,
  output logic [COLOR_W-1:0] bcolor_o,
  output logic               busy,
  output logic [AW-1:0]      cur_idx,
  output logic               arrived
);

  seq_state_t       state;
  logic [PAL_W-1:0] palette [DEPTH];
  logic [PAL_W-1:0] target;
  logic [7:0]       div_cnt;
  logic [15:0]      hold_cnt;
  logic [15:0]      hold_len_q;
  logic             sync_q;
  logic             sync_ev;
  logic             step_en;
  logic             r_at, g_at, b_at, all_at;
  logic [AW-1:0]    next_idx;

  // Resetting sync_q high means a sync_i already high out of reset is not
  // taken as an event.
  assign sync_ev  = sync_i & ~sync_q;
  assign all_at   = r_at & g_at & b_at;
  assign next_idx = (cur_idx >= last_idx) ? '0 : cur_idx + 1'b1;

  // A step is taken on the (step_div+1)-th sync event; '>=' keeps pacing sane
  // if step_div is lowered live below the running count.
  assign step_en  = (state == FADE) && !stop && sync_ev && !all_at &&
                    (div_cnt >= step_div);

  // NOTE: the palette is small and must read as zero after reset, so it is
  // built from resettable flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) palette[i] <= '0;
    end else if (wr_en) begin
      palette[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cur_idx    <= '0;
      target     <= '0;
      div_cnt    <= '0;
      hold_cnt   <= '0;
      hold_len_q <= '0;
      busy       <= 1'b0;
      arrived    <= 1'b0;
      sync_q     <= 1'b1;
    end else begin
      sync_q  <= sync_i;
      arrived <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              cur_idx <= '0;
              target  <= palette[0];
              div_cnt <= '0;
              state   <= FADE;
              busy    <= 1'b1;
            end
          end
          FADE: begin
            if (all_at) begin
              // A sync landing on the completion clk already counts as dwell.
              arrived    <= 1'b1;
              hold_cnt   <= sync_ev ? 16'd1 : 16'd0;
              hold_len_q <= hold_len;
              state      <= HOLD;
            end else if (sync_ev) begin
              div_cnt <= (div_cnt >= step_div) ? 8'd0 : div_cnt + 8'd1;
            end
          end
          HOLD: begin
            if (hold_cnt >= hold_len_q) begin
              cur_idx <= next_idx;
              target  <= palette[next_idx];
              div_cnt <= '0;
              state   <= FADE;
            end else if (sync_ev) begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  rgb_channel_stepper u_red (
    .clk       (clk),
    .rst       (rst),
    .step_en   (step_en),
    .target    (target[R_MSB -: COLOR_W]),
    .value     (rcolor_o),
    .at_target (r_at)
  );

  rgb_channel_stepper u_green (
    .clk       (clk),
    .rst       (rst),
    .step_en   (step_en),
    .target    (target[G_MSB -: COLOR_W]),
    .value     (gcolor_o),
    .at_target (g_at)
  );

  rgb_channel_stepper u_blue (
    .clk       (clk),
    .rst       (rst),
    .step_en   (step_en),
    .target    (target[B_MSB -: COLOR_W]),
    .value     (bcolor_o),
    .at_target (b_at)
  );

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// ---------------------------------------------------------------------------
// tb_rgb_fade_sequencer
// Scoreboard bench: each run predicts the sequence of arrivals (palette index,
// colour, sync events since the previous arrival or start) from the palette
// and timing settings; a monitor pops and compares on every arrived pulse.
// ---------------------------------------------------------------------------
module tb_rgb_fade_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          sync_i;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic [AW-1:0] last_idx;
  logic [7:0]    step_div;
  logic [15:0]   hold_len;
  logic          start, stop;
  logic [7:0]    rcolor_o, gcolor_o, bcolor_o;
  logic          busy;
  logic [AW-1:0] cur_idx;
  logic          arrived;

  always #5 clk = ~clk;

  rgb_fade_sequencer #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .sync_i   (sync_i),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .last_idx (last_idx),
    .step_div (step_div),
    .hold_len (hold_len),
    .start    (start),
    .stop     (stop),
    .rcolor_o (rcolor_o),
    .gcolor_o (gcolor_o),
    .bcolor_o (bcolor_o),
    .busy     (busy),
    .cur_idx  (cur_idx),
    .arrived  (arrived)
  );

  typedef struct {
    int unsigned idx;
    logic [23:0] color;
    int unsigned syncs;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  logic [23:0] pal_m [DEPTH];
  logic [23:0] m_color;
  int          m_next, m_last, m_sd, m_hold;
  bit          m_first;

  function automatic int dist8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? int'(a - b) : int'(b - a);
  endfunction

  function automatic int max_dist(input logic [23:0] a, input logic [23:0] b);
    int d;
    d = dist8(a[23:16], b[23:16]);
    if (dist8(a[15:8], b[15:8]) > d) d = dist8(a[15:8], b[15:8]);
    if (dist8(a[7:0], b[7:0]) > d) d = dist8(a[7:0], b[7:0]);
    return d;
  endfunction

  // Channel value after k unit steps toward t.
  function automatic logic [7:0] mv8(input logic [7:0] a, input logic [7:0] t, input int k);
    int d;
    d = dist8(a, t);
    if (d > k) d = k;
    return (a < t) ? 8'(int'(a) + d) : 8'(int'(a) - d);
  endfunction

  task automatic predict(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.idx   = m_next;
      e.color = pal_m[m_next];
      e.syncs = (m_first ? 0 : m_hold) + max_dist(m_color, e.color) * (m_sd + 1);
      sb.push_back(e);
      m_first = 1'b0;
      m_color = e.color;
      m_next  = (m_next >= m_last) ? 0 : m_next + 1;
    end
  endtask

  // ---------------- sync generator ----------------
  // Rising edges at least 4 clks apart, high for 1..3 clks.
  initial begin : sync_gen
    sync_i = 1'b0;
    forever begin
      int unsigned per, w;
      per = $urandom_range(7, 4);
      w   = $urandom_range(3, 1);
      for (int i = 0; i < int'(per); i++) begin
        @(posedge clk);
        #1 sync_i = (i < int'(w));
      end
    end
  end

  // ---------------- monitor ----------------
  int unsigned sync_cnt = 0;
  int unsigned base     = 0;
  int          arr_cnt  = 0;
  logic        mon_prev = 1'b1;
  exp_t        mon_e;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_prev = 1'b1;
      end else begin
        if (sync_i && !mon_prev) sync_cnt++;
        mon_prev = sync_i;
        if (start && !stop) base = sync_cnt;
        if (arrived) begin
          arr_cnt++;
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_arrived: got arrived=1 want no arrival (idx %0d)", cur_idx);
          end else begin
            mon_e = sb.pop_front();
            check("arr_idx",   32'(cur_idx), mon_e.idx);
            check("arr_rgb",   32'({rcolor_o, gcolor_o, bcolor_o}), 32'(mon_e.color));
            check("arr_syncs", sync_cnt - base, mon_e.syncs);
          end
          base = sync_cnt;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int last, input int sd, input int hold);
    last_idx = AW'(last);
    step_div = 8'(sd);
    hold_len = 16'(hold);
    m_last   = last;
    m_sd     = sd;
    m_hold   = hold;
  endtask

  task automatic write_pal(input int a, input logic [23:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    pal_m[a] = d;
  endtask

  // Start is issued one clk after a sync edge so the first FADE clk never
  // coincides with a sync event.
  task automatic do_start(input int n);
    m_first = 1'b1;
    m_next  = 0;
    predict(n);
    @(posedge sync_i);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("busy_after_stop", 32'(busy), 0);
    check("rgb_after_stop", 32'({rcolor_o, gcolor_o, bcolor_o}), 32'(m_color));
  endtask

  task automatic finish_run(input int goal);
    int cyc = 0;
    while (arr_cnt < goal && cyc < 40000) begin
      tick();
      cyc++;
    end
    check("arrivals_reached", 32'(arr_cnt >= goal), 1);
    do_stop();
  endtask

  task automatic do_run(input int n);
    int goal;
    goal = arr_cnt + n;
    do_start(n);
    finish_run(goal);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rgb"},  32'({rcolor_o, gcolor_o, bcolor_o}), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_arr"},  32'(arrived), 0);
    check({tag, "_idx"},  32'(cur_idx), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin : stim
    int goal;
    logic [23:0] exp_c;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    last_idx = '0; step_div = '0; hold_len = '0; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < DEPTH; i++) pal_m[i] = '0;
    m_color = '0;
    m_first = 1'b0; m_next = 0; m_last = 0; m_sd = 0; m_hold = 0;
    repeat (3) tick();
    check_reset_state("reset0");
    rst = 1'b0;
    tick();

    // Single-entry red ramp, then re-fade to the same colour after dwell.
    configure(0, 0, 2);
    write_pal(0, 24'h0A0000);
    do_run(2);

    // Mixed-direction fade: R falls, G and B rise, B sets the duration.
    configure(1, 0, 2);
    write_pal(1, 24'h0005FF);
    do_run(2);

    // step_div=3: four sync events per colour step.
    configure(0, 3, 1);
    write_pal(0, 24'h0308FC);
    do_run(1);

    // Index wrap with zero dwell: 0,1,2,0,1.
    configure(2, 0, 0);
    write_pal(0, 24'h0309F8);
    write_pal(1, 24'h0709F8);
    write_pal(2, 24'h070CF8);
    do_run(5);

    // Stop part way through a fade: colour frozen at 30 steps in.
    configure(0, 0, 3);
    write_pal(0, 24'hF02080);
    do_start(0);
    repeat (30) @(posedge sync_i);
    tick();
    m_color = {mv8(m_color[23:16], 8'hF0, 30), mv8(m_color[15:8], 8'h20, 30),
               mv8(m_color[7:0], 8'h80, 30)};
    do_stop();
    repeat (6) @(posedge sync_i);
    tick();
    check("rgb_frozen", 32'({rcolor_o, gcolor_o, bcolor_o}), 32'(m_color));

    // start and stop together: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", 32'(busy), 0);
    repeat (3) tick();
    check("start_stop_idle", 32'(busy), 0);

    // Rewrite the targeted entry mid-fade: used on the next visit only.
    configure(0, 0, 1);
    goal = arr_cnt + 2;
    do_start(1);
    write_pal(0, 24'h112131);
    predict(1);
    finish_run(goal);

    // Randomised palettes and pacing.
    for (int r = 0; r < 3; r++) begin
      configure($urandom_range(3, 0), $urandom_range(1, 0), $urandom_range(4, 1));
      for (int i = 0; i < DEPTH; i++) write_pal(i, 24'($urandom));
      do_run(4);
    end

    // Reset from a non-zero colour clears outputs and palette.
    exp_c = m_color;
    check("pre_reset_nonzero", 32'({rcolor_o, gcolor_o, bcolor_o} != 24'h0), 32'(exp_c != 24'h0));
    rst = 1'b1;
    tick();
    check_reset_state("reset1");
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) pal_m[i] = '0;
    m_color = '0;
    tick();
    configure(1, 0, 1);
    do_run(2);

    repeat (4) tick();
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_fade_sequencer.md
Name: rgb_fade_sequencer

Overview:
- Palette-driven colour scheduler that supplies the 8-bit rcolor/gcolor/bcolor inputs of the 8-bit RGB PWM LED controller.
- Steps through a small writable palette of 24-bit colours. Fades linearly from the present colour to each entry, then holds it for a programmable time.
- All timing is paced by the PWM controller's sync output, so colour changes align with PWM cycle starts.

Parameters:
- DEPTH, 4, palette entries; must be a power of two, 2..16.
- AW, $clog2(DEPTH), palette address width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- sync_i  in  1  PWM cycle-start flag from the LED controller, same clock domain; may stay high for more than one clk.
- wr_en  in  1  palette write strobe.
- wr_addr  in  AW  palette write address.
- wr_data  in  24  colour {R[23:16], G[15:8], B[7:0]}.
- last_idx  in  AW  highest palette index used before wrapping to 0.
- step_div  in  8  fade pacing: one step per (step_div+1) sync events.
- hold_len  in  16  sync events to dwell on each reached colour.
- start  in  1  begin sequencing (one-cycle pulse).
- stop  in  1  halt sequencing (one-cycle pulse).
- rcolor_o  out  8  red drive value to the PWM controller.
- gcolor_o  out  8  green drive value to the PWM controller.
- bcolor_o  out  8  blue drive value to the PWM controller.
- busy  out  1  high in FADE or HOLD.
- cur_idx  out  AW  palette index currently targeted.
- arrived  out  1  one-clk pulse when all three channels equal the target.

Behaviour:
- Reset: clk and rst are the only clock and reset; reset is synchronous and active-high.
  - All outputs 0, state IDLE, all palette entries 0, all counters 0.
  - Reset mid-operation aborts immediately; no completion pulse is generated.
- Sync event: a rising edge of sync_i, detected with a registered copy of sync_i that resets to 1. A sync_i held high for N clks counts as one event.
- Palette writes: wr_en writes wr_data to entry wr_addr on the clock edge, in any state.
- Target latching: the target register is loaded from the palette only on FADE entry. A write to the currently targeted entry takes effect on the next visit to that entry.
- State IDLE: outputs frozen. On start with stop low: cur_idx <= 0, target <= palette[0], div counter <= 0, state -> FADE.
- State FADE: on each sync event, the div counter increments.
  - When the div counter reaches step_div, it clears and each channel moves 1 toward its target: +1 if below, -1 if above, unchanged if equal.
  - No overflow or underflow is possible because movement is toward the target only.
  - Completion check runs every clk: when all three channels equal the target, arrived pulses for 1 clk, the hold counter is cleared, and state -> HOLD.
  - If the colour already matches on FADE entry, arrived fires on the first FADE clk (1 clk after entry).
  - Fade duration is max channel distance × (step_div+1) sync events.
- State HOLD: the hold counter increments per sync event.
  - When it equals hold_len (hold_len=0 means immediately, next clk), advance: cur_idx <= (cur_idx >= last_idx) ? 0 : cur_idx+1.
  - On advance: target <= palette[new idx], div counter <= 0, state -> FADE.
  - last_idx and step_div are sampled live. hold_len is sampled at HOLD entry.
- stop: in any state, state -> IDLE on the next edge, colour outputs keep their current values, and busy falls the same edge.
- Simultaneous events:
  - start and stop in the same clk: stop wins.
  - start while busy: ignored.
  - A sync event in the same clk as a state transition is consumed by the new state only if the transition is the FADE-to-HOLD completion; otherwise it is discarded.
- Latency: start to busy high is 1 clk. The first colour step occurs at the (step_div+1)-th sync event after entering FADE.

Decomposition:
- Package rgb_seq_pkg:
  - State encoding IDLE/FADE/HOLD.
  - Colour field positions (R_MSB=23, G_MSB=15, B_MSB=7).
  - Constants COLOR_W=8 and PAL_W=24.
- Sub-module rgb_channel_stepper, instantiated ×3:
  - Holds one 8-bit value.
  - Inputs: step enable, target, load-zero on reset.
  - Outputs: value and an at_target flag.
  - The top-level block ANDs the three at_target flags to detect completion.

Test Plan:
- Reset with outputs previously non-zero -> all colour outputs 0x00, busy=0, arrived=0, cur_idx=0.
- palette[0]=0x0A0000, last_idx=0, step_div=0, hold_len=2, start, sync_i pulse every 256 clk -> red increments 1 per sync, reaches 0x0A after 10 syncs, arrived pulses, 2 syncs of hold, re-FADE with arrived on the next clk.
- From 0x0A0000 to palette[1]=0x0005FF -> R falls, G rises, B rises simultaneously; R and G settle early; arrived only after 255 syncs when B=0xFF.
- step_div=3 -> colour changes exactly once per 4 sync events; a sync_i held high 3 clks counts once.
- last_idx=2, hold_len=0 -> cur_idx sequence 0,1,2,0,1; stop mid-fade freezes colour and busy=0; start+stop in the same clk -> remains IDLE.
- Write palette[cur_idx] during FADE -> current fade target unchanged; the new value is used on the next visit.
